// File: rtl/oct_pkg.sv
// Shared constants and single-digit octal increment/decrement helpers used by
// the step counter's ripple carry/borrow chain.
package oct_pkg;

  localparam int               OCT_W   = 3;
  localparam logic [OCT_W-1:0] OCT_MAX = 3'd7;

  typedef struct packed {
    logic             cy;
    logic [OCT_W-1:0] digit;
  } oct_res_t;

  function automatic oct_res_t oct_inc(input logic [OCT_W-1:0] d, input logic cin);
    oct_res_t r;
    r.cy    = cin && (d == OCT_MAX);
    r.digit = !cin ? d : ((d == OCT_MAX) ? '0 : d + 3'd1);
    return r;
  endfunction

  function automatic oct_res_t oct_dec(input logic [OCT_W-1:0] d, input logic bin);
    oct_res_t r;
    r.cy    = bin && (d == '0);
    r.digit = !bin ? d : ((d == '0) ? OCT_MAX : d - 3'd1);
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability-count debounce and a
// one-cycle press pulse on the debounced 1->0 transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_n_i,
  output logic press_o
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          db_q;
  logic          db_d;
  logic          db_dly_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter only advances while the synchronized level disagrees with the accepted one.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      db_q     <= 1'b1;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw_n_i;
      sync_q   <= meta_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = db_dly_q & ~db_q;

endmodule

// File: rtl/oct_step_counter.sv
// Multi-digit octal up/down counter stepped by a debounced button or a
// free-running tick; registered outputs feed the 7-segment decoders directly.
module oct_step_counter
  import oct_pkg::*;
#(
  parameter int NUM_DIGITS      = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 50000000
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        step_btn_i,
  input  logic                        up_i,
  input  logic                        run_i,
  input  logic                        clear_i,
  output logic [OCT_W*NUM_DIGITS-1:0] digits_o,
  output logic                        carry_o,
  output logic                        step_o
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam int            DW         = OCT_W * NUM_DIGITS;

  logic [2:0]          sw_meta_q;
  logic [2:0]          sw_sync_q;
  logic                up_s, run_s, clear_s;
  logic [PW-1:0]       presc_q;
  logic [PW-1:0]       presc_d;
  logic                tick;
  logic                press;
  logic                step_req;
  logic [DW-1:0]       digits_q, digits_d;
  logic [DW-1:0]       inc_val, dec_val;
  logic [NUM_DIGITS:0] inc_c, dec_b;
  logic                carry_q, carry_d;
  logic                step_q, step_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .raw_n_i (step_btn_i),
    .press_o (press)
  );

  assign {clear_s, run_s, up_s} = sw_sync_q;

  assign tick     = run_s && (presc_q == PRESC_LAST);
  assign presc_d  = (!run_s || tick) ? '0 : presc_q + PW'(1);
  assign step_req = press | tick;

  // Ripple chains: digit 0 always receives the +1/-1, higher digits only on carry/borrow.
  assign inc_c[0] = 1'b1;
  assign dec_b[0] = 1'b1;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    oct_res_t inc_r;
    oct_res_t dec_r;
    assign inc_r                       = oct_inc(digits_q[OCT_W*gi +: OCT_W], inc_c[gi]);
    assign dec_r                       = oct_dec(digits_q[OCT_W*gi +: OCT_W], dec_b[gi]);
    assign inc_val[OCT_W*gi +: OCT_W]  = inc_r.digit;
    assign dec_val[OCT_W*gi +: OCT_W]  = dec_r.digit;
    assign inc_c[gi+1]                 = inc_r.cy;
    assign dec_b[gi+1]                 = dec_r.cy;
  end

  always_comb begin
    digits_d = digits_q;
    carry_d  = 1'b0;
    step_d   = 1'b0;
    if (clear_s) begin
      digits_d = '0;
    end else if (step_req) begin
      step_d = 1'b1;
      if (up_s) begin
        digits_d = inc_val;
        carry_d  = inc_c[NUM_DIGITS];
      end else begin
        digits_d = dec_val;
        carry_d  = dec_b[NUM_DIGITS];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      presc_q   <= '0;
      digits_q  <= '0;
      carry_q   <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      sw_meta_q <= {clear_i, run_i, up_i};
      sw_sync_q <= sw_meta_q;
      presc_q   <= presc_d;
      digits_q  <= digits_d;
      carry_q   <= carry_d;
      step_q    <= step_d;
    end
  end

  assign digits_o = digits_q;
  assign carry_o  = carry_q;
  assign step_o   = step_q;

endmodule

// File: tb/tb_oct_step_counter.sv
// Bench for oct_step_counter: per-cycle comparison against an arithmetic
// model, plus directed scenarios with hand-computed expectations.
module tb_oct_step_counter;

  localparam int ND  = 2;
  localparam int DB  = 4;
  localparam int TD  = 8;
  localparam int MOD = 64;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn   = 1'b1;
  logic          up    = 1'b1;
  logic          run   = 1'b0;
  logic          clr   = 1'b0;
  logic [3*ND-1:0] digits;
  logic          carry;
  logic          step;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_cnt  = 0;
  int last_digits;
  int last_carry;

  oct_step_counter #(
    .NUM_DIGITS      (ND),
    .DEBOUNCE_CYCLES (DB),
    .TICK_DIV        (TD)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .step_btn_i (btn),
    .up_i       (up),
    .run_i      (run),
    .clear_i    (clr),
    .digits_o   (digits),
    .carry_o    (carry),
    .step_o     (step)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Raw inputs exactly as the DUT saw them at the most recent rising edge.
  logic       cap_rst = 1'b0;
  logic [3:0] cap_in  = 4'b0;
  always @(posedge clk) begin
    cap_rst <= rst_n;
    cap_in  <= {btn, up, run, clr};
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (o%0o) required %0d (o%0o) at cycle %0d",
                  name, act, act, exp, exp, cyc_cnt);
  endtask

  // Behavioural model: integer count mod 8^ND, inputs seen two edges late,
  // a level accepted after DB consecutive disagreeing cycles, press acted on one edge later.
  logic [3:0] sync_line[$];
  int   m_count;
  int   m_run_len;
  int   m_presc;
  logic m_db;
  logic m_press_pend;
  logic m_carry;
  logic m_step;

  task automatic model_reset();
    sync_line    = '{4'b0000, 4'b0000};
    m_count      = 0;
    m_run_len    = 0;
    m_presc      = 0;
    m_db         = 1'b1;
    m_press_pend = 1'b0;
    m_carry      = 1'b0;
    m_step       = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] raw);
    logic [3:0] s;
    logic b, u, r, c, press_now, tick_now;
    sync_line.push_back(raw);
    s = sync_line.pop_front();
    {b, u, r, c} = s;
    press_now    = m_press_pend;
    m_press_pend = 1'b0;
    if (b != m_db) begin
      m_run_len++;
      if (m_run_len == DB) begin
        m_press_pend = !b;
        m_db         = b;
        m_run_len    = 0;
      end
    end else begin
      m_run_len = 0;
    end
    tick_now = r && (m_presc == TD - 1);
    m_presc  = r ? (m_presc + 1) % TD : 0;
    m_carry  = 1'b0;
    m_step   = 1'b0;
    if (c) begin
      m_count = 0;
    end else if (press_now || tick_now) begin
      m_step = 1'b1;
      if (u) begin
        m_count = (m_count + 1) % MOD;
        m_carry = (m_count == 0);
      end else begin
        m_count = (m_count + MOD - 1) % MOD;
        m_carry = (m_count == MOD - 1);
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n || !cap_rst) model_reset();
      else model_edge(cap_in);
      check("model_digits", int'(digits), m_count);
      check("model_carry", int'(carry), int'(m_carry));
      check("model_step", int'(step), int'(m_step));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_step(input int budget, output int at_cyc);
    logic ok;
    ok     = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (step) begin
        ok     = 1'b1;
        at_cyc = cyc_cnt;
        break;
      end
    end
    check("step_within_budget", int'(ok), 1);
  endtask

  task automatic count_steps(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (step) cnt++;
    end
  endtask

  task automatic press();
    int t;
    btn = 1'b0;
    wait_step(20, t);
    last_digits = int'(digits);
    last_carry  = int'(carry);
    btn = 1'b1;
    cyc(8);
  endtask

  initial begin
    int t1, t2, n;

    for (int i = 0; i < 6; i++) begin
      cyc(1);
      btn = ~btn; up = ~up; run = ~run; clr = ~clr;
      check("rst_digits", int'(digits), 0);
      check("rst_carry", int'(carry), 0);
      check("rst_step", int'(step), 0);
    end
    btn = 1'b1; up = 1'b1; run = 1'b0; clr = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(4);

    btn = 1'b0;
    cyc(6);
    check("press_c6_digits", int'(digits), 0);
    check("press_c6_step", int'(step), 0);
    cyc(1);
    check("press_c7_digits", int'(digits), 1);
    check("press_c7_step", int'(step), 1);
    cyc(1);
    check("press_c8_step", int'(step), 0);
    cyc(10);
    btn = 1'b1;
    cyc(12);
    check("release_no_step", int'(digits), 1);

    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      cyc(2);
    end
    check("bounce_no_step", int'(digits), 1);
    btn = 1'b0;
    count_steps(20, n);
    check("bounce_step_count", n, 1);
    check("bounce_digits", int'(digits), 2);
    btn = 1'b1;
    cyc(10);

    for (int i = 0; i < 60; i++) press();
    check("preload_76", int'(digits), 'o76);
    run = 1'b1;
    wait_step(20, t1);
    check("wrap_77_digits", int'(digits), 'o77);
    check("wrap_77_carry", int'(carry), 0);
    wait_step(20, t2);
    check("wrap_tick_spacing", t2 - t1, TD);
    check("wrap_00_digits", int'(digits), 0);
    check("wrap_00_carry", int'(carry), 1);
    cyc(1);
    check("wrap_carry_one_cycle", int'(carry), 0);
    run = 1'b0;
    cyc(4);

    for (int i = 0; i < 8; i++) press();
    check("preload_10", int'(digits), 'o10);
    up = 1'b0;
    cyc(3);
    press();
    check("borrow_07_digits", last_digits, 'o07);
    check("borrow_07_carry", last_carry, 0);
    for (int i = 0; i < 7; i++) press();
    check("down_to_00", int'(digits), 0);
    press();
    check("borrow_77_digits", last_digits, 'o77);
    check("borrow_77_carry", last_carry, 1);

    up = 1'b1;
    cyc(3);
    press();
    check("up_wrap_digits", last_digits, 0);
    check("up_wrap_carry", last_carry, 1);

    // Press released into the debouncer so its event lands on the first tick edge.
    run = 1'b1;
    cyc(3);
    btn = 1'b0;
    count_steps(9, n);
    check("coincide_step_count", n, 1);
    check("coincide_digits", int'(digits), 1);
    run = 1'b0;
    count_steps(10, n);
    check("coincide_after_steps", n, 0);
    btn = 1'b1;
    cyc(10);
    check("coincide_hold", int'(digits), 1);

    clr = 1'b1;
    cyc(3);
    check("clear_zero", int'(digits), 0);
    run = 1'b1;
    btn = 1'b0;
    count_steps(25, n);
    check("clear_step_count", n, 0);
    check("clear_digits", int'(digits), 0);
    run = 1'b0;
    btn = 1'b1;
    cyc(10);
    clr = 1'b0;
    count_steps(10, n);
    check("clear_release_steps", n, 0);

    press();
    check("pre_reset_digits", last_digits, 1);
    btn = 1'b0;
    cyc(4);
    rst_n = 1'b0;
    cyc(2);
    check("midreset_digits", int'(digits), 0);
    btn   = 1'b1;
    rst_n = 1'b1;
    count_steps(20, n);
    check("post_reset_steps", n, 0);
    check("post_reset_digits", int'(digits), 0);

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
